// File: rtl/VX_gpu_pkg.sv
// -----------------------------------------------------------------------------
// VX_gpu_pkg
//   Shared GPU-core definitions used by the ALU vote aggregation slice.
//   - vote_op_t    : INST_VOTE_* operation encodings
//   - vote_state_t : vote aggregator FSM states
//   - up_clog2     : clog2 clamped to a minimum of 1 bit (index widths)
// -----------------------------------------------------------------------------
package VX_gpu_pkg;

   typedef enum logic [1:0] {
      INST_VOTE_ALL = 2'd0,
      INST_VOTE_ANY = 2'd1,
      INST_VOTE_UNI = 2'd2,
      INST_VOTE_BAL = 2'd3
   } vote_op_t;

   typedef enum logic {
      VOTE_ACCUM = 1'b0,
      VOTE_DRAIN = 1'b1
   } vote_state_t;

   // A field indexing n items still needs one bit when n == 1.
   function automatic int up_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_alu_vote_agg_if.sv
// -----------------------------------------------------------------------------
// vx_alu_vote_agg_if
//   Packet-stream interface of the warp vote aggregator.
//   Input side : in_valid/in_ready handshake with op, tmask, pred, pid,
//                sop/eop framing and an opaque tag.
//   Output side: out_valid/out_ready handshake with the vote result replicated
//                per lane plus the replayed tmask, pid, sop/eop and tag.
//   Modports   : slave  = the aggregator
//                master = the upstream/downstream environment
// -----------------------------------------------------------------------------
interface vx_alu_vote_agg_if
   import VX_gpu_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int NUM_PACKETS = 2,
   parameter int XLEN        = 32,
   parameter int TAG_WIDTH   = 16,
   parameter int PID_WIDTH   = up_clog2(NUM_PACKETS)
);

   logic                      in_valid;
   logic                      in_ready;
   vote_op_t                  in_op;
   logic [NUM_LANES-1:0]      in_tmask;
   logic [NUM_LANES-1:0]      in_pred;
   logic [PID_WIDTH-1:0]      in_pid;
   logic                      in_sop;
   logic                      in_eop;
   logic [TAG_WIDTH-1:0]      in_tag;

   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_LANES*XLEN-1:0] out_data;
   logic [NUM_LANES-1:0]      out_tmask;
   logic [PID_WIDTH-1:0]      out_pid;
   logic                      out_sop;
   logic                      out_eop;
   logic [TAG_WIDTH-1:0]      out_tag;

   modport slave (
      input  in_valid, in_op, in_tmask, in_pred, in_pid, in_sop, in_eop, in_tag,
      input  out_ready,
      output in_ready,
      output out_valid, out_data, out_tmask, out_pid, out_sop, out_eop, out_tag
   );

   modport master (
      output in_valid, in_op, in_tmask, in_pred, in_pid, in_sop, in_eop, in_tag,
      output out_ready,
      input  in_ready,
      input  out_valid, out_data, out_tmask, out_pid, out_sop, out_eop, out_tag
   );

endinterface

// File: rtl/vx_vote_pkt_buf.sv
// -----------------------------------------------------------------------------
// vx_vote_pkt_buf
//   NUM_PACKETS-deep packet store for one warp instruction. Packets are
//   written in order at slot `count` and read back combinationally at slot
//   `rd_idx`. No write-to-read bypass.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : store wr_data at slot count, count++
//   wr_data    : packed packet record
//   rd_en      : advance rd_idx
//   clear      : drop all stored packets (count = rd_idx = 0), wins over rd_en
//   count      : number of stored packets
//   rd_idx     : slot currently presented on rd_data
//   rd_data    : packet record at rd_idx
// -----------------------------------------------------------------------------
module vx_vote_pkt_buf #(
   parameter int NUM_PACKETS = 2,
   parameter int WIDTH       = 8,
   parameter int CNT_W       = $clog2(NUM_PACKETS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [NUM_PACKETS];

   // NOTE: storage has no reset; count gates what is ever read, so stale
   // slot contents are never visible and the array maps to plain registers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PACKETS; i++) begin
         if (wr_en && (count == CNT_W'(i))) begin
            mem[i] <= wr_data;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count  <= '0;
         rd_idx <= '0;
      end else begin
         if (wr_en) count  <= count + CNT_W'(1);
         if (rd_en) rd_idx <= rd_idx + CNT_W'(1);
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_PACKETS; i++) begin
         if (rd_idx == CNT_W'(i)) rd_data = mem[i];
      end
   end

endmodule

// File: rtl/vx_alu_vote_agg.sv
// -----------------------------------------------------------------------------
// vx_alu_vote_agg
//   Warp-wide vote/ballot unit for warps split into several lane packets.
//   ACCUM: packets are buffered and their predicates folded into warp-wide
//          accumulators; the op of the first packet of a group is latched.
//   DRAIN: after eop (or a full buffer), every buffered packet is replayed in
//          arrival order with the warp vote result in every lane.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, discards any partial group
//   bus   : vx_alu_vote_agg_if.slave packet-in / packet-out streams
// -----------------------------------------------------------------------------
module vx_alu_vote_agg
   import VX_gpu_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int NUM_PACKETS = 2,
   parameter int XLEN        = 32,
   parameter int TAG_WIDTH   = 16
) (
   input  logic                clk,
   input  logic                reset,
   vx_alu_vote_agg_if.slave    bus
);

   localparam int PID_WIDTH = up_clog2(NUM_PACKETS);
   localparam int CNT_W     = $clog2(NUM_PACKETS + 1);
   localparam int BAL_W     = NUM_LANES * NUM_PACKETS;
   localparam int PKT_W     = NUM_LANES + PID_WIDTH + 2 + TAG_WIDTH;

   if (BAL_W > XLEN) begin : g_bad_cfg
      $error("vx_alu_vote_agg: NUM_LANES*NUM_PACKETS exceeds XLEN");
   end

   vote_state_t       state_q, state_n;
   logic              has_true_q, has_true_n;
   logic              has_false_q, has_false_n;
   logic [BAL_W-1:0]  ballot_q, ballot_n;
   vote_op_t          op_q, op_n;
   logic [XLEN-1:0]   result_q, result_n;
   logic              vote_all, vote_uni;

   logic [CNT_W-1:0]  count, rd_idx;
   logic [PKT_W-1:0]  wr_pkt, rd_pkt;
   logic [NUM_LANES-1:0] lane_true, lane_false;
   logic              full, in_fire, out_fire, last_out, drain_done, pid_ok;

   assign full         = (count == CNT_W'(NUM_PACKETS));
   assign bus.in_ready = (state_q == VOTE_ACCUM) && !full;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state_q == VOTE_DRAIN);
   assign out_fire     = bus.out_valid && bus.out_ready;
   // In DRAIN count is always >= 1, so count-1 never wraps there.
   assign last_out     = (rd_idx == count - CNT_W'(1));
   assign drain_done   = out_fire && last_out;

   assign lane_true  = bus.in_tmask & bus.in_pred;
   assign lane_false = bus.in_tmask & ~bus.in_pred;

   assign wr_pkt = {bus.in_tmask, bus.in_pid, bus.in_sop, bus.in_eop, bus.in_tag};
   assign {bus.out_tmask, bus.out_pid, bus.out_sop, bus.out_eop, bus.out_tag} = rd_pkt;
   assign bus.out_data = {NUM_LANES{result_q}};

   vx_vote_pkt_buf #(
      .NUM_PACKETS (NUM_PACKETS),
      .WIDTH       (PKT_W),
      .CNT_W       (CNT_W)
   ) u_pkt_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_fire),
      .wr_data (wr_pkt),
      .rd_en   (out_fire),
      .clear   (drain_done),
      .count   (count),
      .rd_idx  (rd_idx),
      .rd_data (rd_pkt)
   );

   // NOTE: every always_comb output is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_n     = state_q;
      has_true_n  = has_true_q;
      has_false_n = has_false_q;
      ballot_n    = ballot_q;
      op_n        = op_q;
      pid_ok      = 1'b0;

      // An out-of-range pid matches no slice, so its ballot bits are dropped.
      for (int p = 0; p < NUM_PACKETS; p++) begin
         if (bus.in_pid == PID_WIDTH'(p)) begin
            pid_ok = 1'b1;
            if (in_fire) begin
               ballot_n[p*NUM_LANES +: NUM_LANES] =
                  ballot_q[p*NUM_LANES +: NUM_LANES] | lane_true;
            end
         end
      end

      case (state_q)
         VOTE_ACCUM: begin
            if (in_fire) begin
               has_true_n  = has_true_q  | (|lane_true);
               has_false_n = has_false_q | (|lane_false);
               if (count == '0) op_n = bus.in_op;
               if (bus.in_eop) state_n = VOTE_DRAIN;
            end else if (full) begin
               // Group never closed: replay what is stored rather than stall.
               state_n = VOTE_DRAIN;
            end
         end
         VOTE_DRAIN: begin
            if (drain_done) begin
               state_n     = VOTE_ACCUM;
               has_true_n  = 1'b0;
               has_false_n = 1'b0;
               ballot_n    = '0;
            end
         end
         default: state_n = VOTE_ACCUM;
      endcase

      // Result from the post-update accumulators so the eop packet counts.
      vote_all = ~has_false_n;
      vote_uni = vote_all | ~has_true_n;
      case (op_n)
         INST_VOTE_ALL: result_n = XLEN'(vote_all);
         INST_VOTE_ANY: result_n = XLEN'(has_true_n);
         INST_VOTE_UNI: result_n = XLEN'(vote_uni);
         default:       result_n = XLEN'(ballot_n);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= VOTE_ACCUM;
         has_true_q  <= 1'b0;
         has_false_q <= 1'b0;
         ballot_q    <= '0;
         op_q        <= INST_VOTE_ALL;
         result_q    <= '0;
      end else begin
         state_q     <= state_n;
         has_true_q  <= has_true_n;
         has_false_q <= has_false_n;
         ballot_q    <= ballot_n;
         op_q        <= op_n;
         // Result is frozen for the whole DRAIN phase.
         if ((state_q == VOTE_ACCUM) && (state_n == VOTE_DRAIN)) begin
            result_q <= result_n;
         end
      end
   end

   a_missing_eop : assert property (@(posedge clk) disable iff (reset)
      !((state_q == VOTE_ACCUM) && full))
      else $error("missing eop");

   a_pid_range : assert property (@(posedge clk) disable iff (reset)
      in_fire |-> pid_ok)
      else $error("vote pid out of range");

endmodule

// File: tb/tb_vx_alu_vote_agg.sv
module tb_vx_alu_vote_agg;
   import VX_gpu_pkg::*;

   localparam int NL = 4;
   localparam int NP = 2;
   localparam int XL = 32;
   localparam int TW = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vx_alu_vote_agg_if #(.NUM_LANES(NL), .NUM_PACKETS(NP), .XLEN(XL), .TAG_WIDTH(TW)) bus ();

   vx_alu_vote_agg #(.NUM_LANES(NL), .NUM_PACKETS(NP), .XLEN(XL), .TAG_WIDTH(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one packet and hold it until it is accepted (bounded wait).
   task automatic send_pkt(input vote_op_t op, input logic [3:0] tm, input logic [3:0] pr,
                           input logic pid, input logic sop, input logic eop,
                           input logic [15:0] tag);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_tmask = tm;
      bus.in_pred  = pr;
      bus.in_pid   = pid;
      bus.in_sop   = sop;
      bus.in_eop   = eop;
      bus.in_tag   = tag;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check($sformatf("in_ready tag=%0h", tag), 128'(bus.in_ready), 128'(1'b1));
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Wait (bounded) for one output packet, compare all fields, then let it fire.
   task automatic expect_out(input string name, input logic pid, input logic [3:0] tm,
                             input logic sop, input logic eop, input logic [15:0] tag,
                             input logic [31:0] res);
      int n = 0;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      check({name, " out_valid"}, 128'(bus.out_valid), 128'(1'b1));
      check({name, " out_data"},  128'(bus.out_data),  128'({4{res}}));
      check({name, " out_pid"},   128'(bus.out_pid),   128'(pid));
      check({name, " out_tmask"}, 128'(bus.out_tmask), 128'(tm));
      check({name, " out_sop"},   128'(bus.out_sop),   128'(sop));
      check({name, " out_eop"},   128'(bus.out_eop),   128'(eop));
      check({name, " out_tag"},   128'(bus.out_tag),   128'(tag));
      tick();
   endtask

   typedef struct {
      vote_op_t    op;
      int          npk;
      logic [3:0]  tm0;
      logic [3:0]  pr0;
      logic [3:0]  tm1;
      logic [3:0]  pr1;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [31:0] snap_data;
      logic [15:0] snap_tag;
      logic        snap_pid;
      logic [3:0]  snap_tm;
      string       nm;
      logic [15:0] t0;
      vote_op_t    op1;

      vecs[0] = '{INST_VOTE_ALL, 2, 4'hF, 4'hF, 4'h3, 4'h1, 32'h0000_0000};
      vecs[1] = '{INST_VOTE_ANY, 2, 4'hF, 4'h0, 4'h8, 4'h8, 32'h0000_0001};
      vecs[2] = '{INST_VOTE_BAL, 2, 4'hF, 4'hA, 4'h7, 4'h6, 32'h0000_006A};
      vecs[3] = '{INST_VOTE_UNI, 2, 4'h0, 4'hF, 4'h0, 4'h0, 32'h0000_0001};
      vecs[4] = '{INST_VOTE_UNI, 1, 4'hF, 4'h5, 4'h0, 4'h0, 32'h0000_0000};
      vecs[5] = '{INST_VOTE_ALL, 2, 4'hF, 4'hF, 4'hF, 4'hF, 32'h0000_0001};
      vecs[6] = '{INST_VOTE_ANY, 2, 4'h0, 4'hF, 4'h0, 4'hF, 32'h0000_0000};
      vecs[7] = '{INST_VOTE_BAL, 1, 4'hF, 4'hF, 4'h0, 4'h0, 32'h0000_000F};
      vecs[8] = '{INST_VOTE_ALL, 2, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0001};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = INST_VOTE_ALL;
      bus.in_tmask  = '0;
      bus.in_pred   = '0;
      bus.in_pid    = '0;
      bus.in_sop    = 1'b0;
      bus.in_eop    = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      check("reset out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("reset in_ready",  128'(bus.in_ready),  128'(1'b1));
      check("reset out_data",  128'(bus.out_data),  128'(0));

      // Table-driven groups; pkt1 carries a different op that must be ignored.
      for (int i = 0; i < 9; i++) begin
         t0  = 16'hA000 + 16'(i * 16);
         op1 = vote_op_t'(vecs[i].op ^ 2'b11);
         bus.out_ready = 1'b1;
         if (vecs[i].npk == 1) begin
            send_pkt(vecs[i].op, vecs[i].tm0, vecs[i].pr0, 1'b0, 1'b1, 1'b1, t0);
         end else begin
            send_pkt(vecs[i].op, vecs[i].tm0, vecs[i].pr0, 1'b0, 1'b1, 1'b0, t0);
            send_pkt(op1,        vecs[i].tm1, vecs[i].pr1, 1'b1, 1'b0, 1'b1, t0 + 16'd1);
         end
         nm = $sformatf("vec%0d", i);
         check({nm, " latency out_valid"}, 128'(bus.out_valid), 128'(1'b1));
         check({nm, " drain in_ready"},    128'(bus.in_ready),  128'(1'b0));
         if (vecs[i].npk == 1) begin
            expect_out({nm, " p0"}, 1'b0, vecs[i].tm0, 1'b1, 1'b1, t0, vecs[i].exp);
         end else begin
            expect_out({nm, " p0"}, 1'b0, vecs[i].tm0, 1'b1, 1'b0, t0, vecs[i].exp);
            expect_out({nm, " p1"}, 1'b1, vecs[i].tm1, 1'b0, 1'b1, t0 + 16'd1, vecs[i].exp);
         end
         check({nm, " done out_valid"}, 128'(bus.out_valid), 128'(1'b0));
         check({nm, " done in_ready"},  128'(bus.in_ready),  128'(1'b1));
      end

      // Backpressure at the first DRAIN output.
      bus.out_ready = 1'b0;
      send_pkt(INST_VOTE_BAL, 4'hF, 4'hA, 1'b0, 1'b1, 1'b0, 16'hB000);
      send_pkt(INST_VOTE_BAL, 4'h7, 4'h6, 1'b1, 1'b0, 1'b1, 16'hB001);
      check("bp first out_valid", 128'(bus.out_valid), 128'(1'b1));
      snap_data = bus.out_data[31:0];
      snap_tag  = bus.out_tag;
      snap_pid  = bus.out_pid;
      snap_tm   = bus.out_tmask;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp hold%0d out_valid", c), 128'(bus.out_valid), 128'(1'b1));
         check($sformatf("bp hold%0d out_data", c),  128'(bus.out_data),  128'({4{snap_data}}));
         check($sformatf("bp hold%0d out_tag", c),   128'(bus.out_tag),   128'(snap_tag));
         check($sformatf("bp hold%0d out_pid", c),   128'(bus.out_pid),   128'(snap_pid));
         check($sformatf("bp hold%0d out_tmask", c), 128'(bus.out_tmask), 128'(snap_tm));
         check($sformatf("bp hold%0d in_ready", c),  128'(bus.in_ready),  128'(1'b0));
      end
      bus.out_ready = 1'b1;
      expect_out("bp p0", 1'b0, 4'hF, 1'b1, 1'b0, 16'hB000, 32'h0000_006A);
      expect_out("bp p1", 1'b1, 4'h7, 1'b0, 1'b1, 16'hB001, 32'h0000_006A);
      check("bp done out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("bp done in_ready",  128'(bus.in_ready),  128'(1'b1));
      // Fresh accumulators: the previous group had true lanes, this one none.
      send_pkt(INST_VOTE_ANY, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 16'hB010);
      expect_out("bp fresh", 1'b0, 4'hF, 1'b1, 1'b1, 16'hB010, 32'h0000_0000);
      check("bp fresh done out_valid", 128'(bus.out_valid), 128'(1'b0));

      // Reset with pkt0 of a group already buffered.
      send_pkt(INST_VOTE_ANY, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 16'hC000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst mid out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("rst mid in_ready",  128'(bus.in_ready),  128'(1'b1));
      send_pkt(INST_VOTE_ANY, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 16'hC001);
      check("rst latency out_valid", 128'(bus.out_valid), 128'(1'b1));
      expect_out("rst single", 1'b0, 4'hF, 1'b1, 1'b1, 16'hC001, 32'h0000_0000);
      check("rst single done out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("rst single done in_ready",  128'(bus.in_ready),  128'(1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
